// File: rtl/sap1_pkg.sv
// Shared definitions for the program loader: FSM state encoding and
// default program-memory geometry.
package sap1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int PROG_WORDS = 16;
    localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, memory write port and CPU status lines of the loader.
// master: the board-level source / testbench side. slave: the loader.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error
    );
endinterface

// File: rtl/loader_datapath.sv
// Word counter, running checksum and registered memory write port.
// The counter carries one extra bit so "all data words received" is just
// its MSB; it never wraps within a load because the FSM leaves the data
// phase once that bit is set.
module loader_datapath #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,      // restart: zero counter and sum
    input  logic                  wr_en,    // data word accepted
    input  logic                  acc_en,   // checksum byte accepted
    input  logic [DATA_WIDTH-1:0] din,
    output logic [ADDR_WIDTH:0]   cnt,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data
);
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Next-state: write strobe is a single-cycle pulse per accepted word;
    // the sum wraps naturally at DATA_WIDTH bits.
    always_comb begin
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (clr) begin
            cnt_d = '0;
            sum_d = '0;
        end else if (wr_en) begin
            we_d   = 1'b1;
            addr_d = cnt_q[ADDR_WIDTH-1:0];
            data_d = din;
            cnt_d  = cnt_q + 1'b1;
            sum_d  = sum_q + din;
        end else if (acc_en) begin
            sum_d = sum_q + din;
        end
    end

    // Datapath registers; reset does not touch memory, only the write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            sum_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign cnt      = cnt_q;
    assign sum      = sum_q;
    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
endmodule

// File: rtl/program_loader.sv
// Program loader: accepts a byte stream, writes it into program memory and
// keeps the CPU held in reset until a complete load (with a good trailing
// checksum when enabled) has been seen.
module program_loader #(
    parameter int ADDR_WIDTH  = $clog2(sap1_pkg::PROG_WORDS),
    parameter int DATA_WIDTH  = sap1_pkg::DATA_WIDTH,
    parameter bit CHECKSUM_EN = 1'b1
) (
    input logic              clock,
    input logic              reset,
    program_loader_if.slave  bus
);
    import sap1_pkg::loader_state_t;
    import sap1_pkg::IDLE;
    import sap1_pkg::LOAD;
    import sap1_pkg::CHECK;
    import sap1_pkg::DONE;
    import sap1_pkg::ERROR;

    loader_state_t         state_q, state_d;
    logic                  clr, wr_en, acc_en;
    logic [ADDR_WIDTH:0]   cnt;
    logic [DATA_WIDTH-1:0] sum;
    logic                  in_ready, cpu_hold, done, error;

    loader_datapath #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dp (
        .clock    (clock),
        .reset    (reset),
        .clr      (clr),
        .wr_en    (wr_en),
        .acc_en   (acc_en),
        .din      (bus.in_data),
        .cnt      (cnt),
        .sum      (sum),
        .mem_we   (bus.mem_we),
        .mem_addr (bus.mem_addr),
        .mem_data (bus.mem_data)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and datapath controls. start wins over any transfer in the
    // same cycle, so a byte presented alongside start is dropped. in_ready
    // is high exactly in LOAD, so in_valid in LOAD is a transfer.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        wr_en   = 1'b0;
        acc_en  = 1'b0;
        if (bus.start) begin
            state_d = LOAD;
            clr     = 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.in_valid) begin
                        if (!cnt[ADDR_WIDTH]) begin
                            wr_en = 1'b1;
                            if (!CHECKSUM_EN && (cnt[ADDR_WIDTH-1:0] == '1))
                                state_d = DONE;
                        end else begin
                            // Only reachable with the checksum enabled.
                            acc_en  = 1'b1;
                            state_d = CHECK;
                        end
                    end
                end
                // The checksum byte is already folded into sum, so a good
                // load leaves it at zero.
                CHECK:   state_d = (sum == '0) ? DONE : ERROR;
                default: state_d = state_q;
            endcase
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        in_ready = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            LOAD:    in_ready = 1'b1;
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ERROR:   error = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign bus.in_ready = in_ready;
    assign bus.cpu_hold = cpu_hold;
    assign bus.done     = done;
    assign bus.error    = error;
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes and
// load outcomes into queues, monitors pop and compare as the DUT produces them.
module tb_program_loader;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHECKSUM_EN(1'b1)) u_dut (
        .clock (clock), .reset (reset), .bus (bus)
    );
    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHECKSUM_EN(1'b0)) u_dut0 (
        .clock (clock), .reset (reset), .bus (bus0)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int   tests = 0;
    int   fails = 0;
    wr_t  exp_q[$];        // expected memory writes, in order
    logic [1:0] stat_q[$]; // expected {done,error} at end of each load
    int   loaded;          // data words accepted since the last start
    int   sum;             // model running sum mod 256
    int   w0;              // writes seen from the checksum-less instance
    logic prev_done, prev_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the main instance.
    always @(posedge clock) begin
        wr_t  e;
        logic [1:0] s;
        #1;
        if (!reset) begin
            if (bus.mem_we) begin
                if (exp_q.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.mem_addr, e.addr);
                    check("wr_data", bus.mem_data, e.data);
                end
            end
            if ((bus.done && !prev_done) || (bus.error && !prev_err)) begin
                if (stat_q.size() == 0) check("unexpected_status", 1, 0);
                else begin
                    s = stat_q.pop_front();
                    check("status", {bus.done, bus.error}, s);
                    check("hold_vs_done", bus.cpu_hold, !s[1]);
                end
            end
        end
        prev_done = bus.done;
        prev_err  = bus.error;
    end

    // Monitor for the checksum-less instance: contiguous 0xFF writes.
    always @(posedge clock) begin
        #1;
        if (!reset && bus0.mem_we) begin
            check("en0_addr", bus0.mem_addr, w0[AW-1:0]);
            check("en0_data", bus0.mem_data, 8'hFF);
            w0++;
        end
    end

    // All tasks start and end just after a falling edge.
    task automatic pulse_start();
        bus.start    = 1'b1;
        bus.in_valid = 1'b0;
        loaded = 0;
        sum    = 0;
        @(posedge clock); @(negedge clock);
        bus.start = 1'b0;
        check("load_ready", bus.in_ready, 1);
        check("load_hold", bus.cpu_hold, 1);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int guard = 0;
        int g = 0;
        while (g < 4 && $urandom_range(99) < gap) begin
            bus.in_valid = 1'b0;
            @(posedge clock); @(negedge clock);
            g++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready) begin
            @(posedge clock); @(negedge clock);
            guard++;
            if (guard > 50) begin
                check("ready_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        // Handshake happens on the coming rising edge.
        if (loaded < N) begin
            wr_t e;
            e.addr = loaded[AW-1:0];
            e.data = b;
            exp_q.push_back(e);
            loaded++;
        end
        sum = (sum + b) % 256;
        @(posedge clock); @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input logic [N-1:0][7:0] d, input logic [7:0] cks,
                        input int gap, input bit do_start);
        bit good;
        if (do_start) pulse_start();
        for (int i = 0; i < N; i++) send(d[i], gap);
        good = (((sum + cks) % 256) == 0);
        stat_q.push_back(good ? 2'b10 : 2'b01);
        send(cks, gap);
        // One cycle in the checksum-check state.
        check("check_ready", bus.in_ready, 0);
        check("check_done", bus.done, 0);
        check("check_hold", bus.cpu_hold, 1);
        @(posedge clock); @(negedge clock);
        check("end_done", bus.done, good);
        check("end_error", bus.error, !good);
        check("end_hold", bus.cpu_hold, !good);
        check("end_ready", bus.in_ready, 0);
        check("writes_left", exp_q.size(), 0);
        check("status_left", stat_q.size(), 0);
    endtask

    function automatic logic [7:0] good_cks(input logic [N-1:0][7:0] d);
        int s = 0;
        for (int i = 0; i < N; i++) s += d[i];
        return 8'((256 - (s % 256)) % 256);
    endfunction

    initial begin
        logic [N-1:0][7:0] d;
        logic [7:0] cks;
        int n, guard;

        bus.start = 1'b0;  bus.in_valid = 1'b0;  bus.in_data = '0;
        bus0.start = 1'b0; bus0.in_valid = 1'b0; bus0.in_data = '0;
        loaded = 0; sum = 0; w0 = 0;
        prev_done = 1'b0; prev_err = 1'b0;

        #2;
        check("rst_ready", bus.in_ready, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_data", bus.mem_data, 0);
        check("rst_hold", bus.cpu_hold, 1);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", bus.in_ready, 0);

        // Directed good load 0x00..0x0F with checksum 0x88.
        for (int i = 0; i < N; i++) d[i] = 8'(i);
        check("model_cks", good_cks(d), 8'h88);
        load(d, 8'h88, 0, 1'b1);
        // Bad checksum, then recover.
        load(d, 8'h87, 0, 1'b1);
        load(d, 8'h88, 0, 1'b1);

        // Random data, random gaps, good or corrupted checksum.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) d[i] = 8'($urandom);
            cks = good_cks(d);
            if ($urandom_range(1) == 0) cks = cks + 8'($urandom_range(255, 1));
            load(d, cks, 60, 1'b1);
        end

        // Restart after 5 transfers, with 0xAA presented alongside start.
        pulse_start();
        for (int i = 0; i < 5; i++) send(8'(i + 1), 0);
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hAA;
        loaded = 0; sum = 0;
        @(posedge clock); @(negedge clock);
        bus.start = 1'b0; bus.in_valid = 1'b0;
        check("restart_we", bus.mem_we, 0);
        check("restart_ready", bus.in_ready, 1);
        for (int i = 0; i < N; i++) d[i] = 8'($urandom);
        load(d, good_cks(d), 30, 1'b0);

        // Asynchronous reset mid-load, mid-cycle, while a write is showing.
        pulse_start();
        for (int i = 0; i < 3; i++) send(8'(i + 8'h40), 0);
        #2 reset = 1'b1;
        #1;
        check("arst_ready", bus.in_ready, 0);
        check("arst_we", bus.mem_we, 0);
        check("arst_addr", bus.mem_addr, 0);
        check("arst_hold", bus.cpu_hold, 1);
        check("arst_done", bus.done, 0);
        check("arst_error", bus.error, 0);
        exp_q.delete(); stat_q.delete();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        load(d, good_cks(d), 0, 1'b1);

        // Checksum-less instance: 16 x 0xFF, in_valid held high throughout.
        w0 = 0;
        bus0.start = 1'b1;
        @(posedge clock); @(negedge clock);
        bus0.start = 1'b0;
        bus0.in_valid = 1'b1; bus0.in_data = 8'hFF;
        n = 0; guard = 0;
        while (n < N && guard < 100) begin
            if (bus0.in_ready) n++;
            @(posedge clock); @(negedge clock);
            guard++;
        end
        check("en0_xfers", n, N);
        check("en0_done", bus0.done, 1);
        check("en0_ready", bus0.in_ready, 0);
        check("en0_hold", bus0.cpu_hold, 0);
        repeat (3) @(negedge clock);
        check("en0_no17", bus0.in_ready, 0);
        check("en0_writes", w0, N);
        bus0.in_valid = 1'b0;

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the 16x8 program memory: receives a program byte stream over a valid/ready handshake and writes it word by word into memory.
- Holds the CPU (PC, control unit, registers) in reset while loading, and checks an 8-bit checksum before releasing it.
- Sits between the board-level input source (switches, UART byte receiver) and the memory write port. It is the counterpart of the processor's read-only fetch path.

Parameters:
- ADDR_WIDTH, 4, memory address width; program length is 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, word width of the stream and the memory.
- CHECKSUM_EN, 1: when 1, a trailing checksum byte is required. When 0, the load completes after the last data word.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a (re)load.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  DATA_WIDTH  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  memory write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_data  output  DATA_WIDTH  write data.
- cpu_hold  output  1  drives the CPU reset (ORed with reset at top level).
- done  output  1  level: last load completed with a good checksum.
- error  output  1  level: last load failed its checksum.

Behaviour:
- Reset (asynchronous, active-high) applies these values:
  - state = IDLE
  - word counter = 0, running sum = 0
  - in_ready = 0, mem_we = 0, mem_addr = 0, mem_data = 0
  - cpu_hold = 1, done = 0, error = 0
- Reset mid-load aborts the load. Memory contents already written are left unchanged.
- A transfer occurs on a rising edge where in_valid && in_ready. The source must hold in_data stable while in_valid=1 && in_ready=0.
- States:
  - IDLE: in_ready=0, cpu_hold=1. start -> LOAD.
  - LOAD: in_ready=1, cpu_hold=1, done=0, error=0.
    - Transfer k, for k < 2**ADDR_WIDTH: next cycle mem_we=1, mem_addr=k, mem_data=byte (1-cycle latency, registered outputs). The counter increments and sum += byte, mod 2**DATA_WIDTH.
    - After the last data word: CHECKSUM_EN=1 stays in LOAD for one more transfer (the checksum byte, not written to memory); CHECKSUM_EN=0 goes to DONE.
    - Checksum transfer -> CHECK.
  - CHECK (1 cycle): in_ready=0. If (sum + checksum_byte) mod 256 == 0 -> DONE, else -> ERROR.
  - DONE: cpu_hold=0, done=1, in_ready=0. start -> LOAD.
  - ERROR: cpu_hold=1, error=1, in_ready=0. start -> LOAD.
- mem_we is never asserted outside the cycle after a data transfer. There are at most 2**ADDR_WIDTH writes per load.
- Counter wrap: the counter never wraps within a load. It reaches the last address and the FSM leaves data phase.
- start while in LOAD restarts the load: counter=0, sum=0, and any transfer in that same cycle is discarded. start has priority over in_valid.
- start in DONE reasserts cpu_hold on the next cycle, restarting the CPU after the reload.
- in_valid while in_ready=0 is ignored; no data is lost because the source holds.
- in_valid deasserted mid-load means the loader waits indefinitely in LOAD. There is no timeout.

Decomposition:
- Shared package (sap1_pkg):
  - state encoding typedef loader_state_t {IDLE, LOAD, CHECK, DONE, ERROR}
  - PROG_WORDS = 16
  - DATA_WIDTH = 8
- One natural sub-module: loader_datapath, holding the word counter, checksum accumulator and write-port registers. It is controlled by the FSM in program_loader.
- The top level adds a write port to memory_16x8 and ORs cpu_hold into the CPU reset.

Test Plan:
- Reset value check: assert reset asynchronously mid-cycle -> all outputs take their reset values immediately (in_ready=0, mem_we=0, cpu_hold=1, done=0, error=0).
- Good load: start, stream bytes 0x00..0x0F with in_valid always 1, then checksum 0x88 (sum 0x78) ->
  - 16 mem_we pulses, addr 0..15, data = addr
  - CHECK, then done=1, cpu_hold=0 two cycles after the checksum transfer.
- Bad checksum: same stream, checksum 0x87 -> error=1, cpu_hold stays 1, done=0. A second start followed by a correct stream -> done=1.
- Back-pressure/gaps: in_valid toggled randomly (e.g. 1-0-0-1) across the load -> writes occur only on handshakes, and addresses stay contiguous 0..15.
- Restart: start asserted after 5 transfers, same cycle as a valid byte 0xAA -> 0xAA is not written, and the next transfer writes addr 0.
- CHECKSUM_EN=0: 16 bytes of 0xFF -> done=1 one cycle after the 16th write, with no 17th transfer accepted (in_ready=0).
